// File: rtl/jtag_debug_scan_master_if.sv
// Command/response bundle between a scan initiator and the
// JTAG debug scan master.
interface jtag_debug_scan_master_if #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_dr;
  logic                rsp_valid;
  logic [DR_WIDTH-1:0] rsp_data;
  logic                busy;

  modport master (
    output cmd_valid, cmd_ir, cmd_dr,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_dr,
    output cmd_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/jtag_debug_scan_master.sv
// Virtual-JTAG scan master: UIR/CDR/SDR/UDR sequence on a divided TCK.
// Optional JTAG_SCAN_MASTER_IR_SKIP_EN skips UIR when the IR is unchanged.
module jtag_debug_scan_master #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  jtag_debug_scan_master_if.slave cmd,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_rti,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr
);

  localparam int CW = $clog2(2 * TCK_DIV);
  localparam int BW = $clog2(DR_WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(2 * TCK_DIV - 1);
  localparam logic [CW-1:0] C_RISE = CW'(TCK_DIV - 1);
  localparam logic [CW-1:0] C_HI   = CW'(TCK_DIV);
  localparam logic [BW-1:0] B_LAST = BW'(DR_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UIR, S_CDR, S_SHIFT, S_UDR, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       c_q, c_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DR_WIDTH-1:0] tx_q, tx_d;
  logic [DR_WIDTH-1:0] rx_q, rx_d;
  logic [DR_WIDTH-1:0] rsp_q, rsp_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                tck_q, tck_d;
  logic                accept, period_end;
`ifdef JTAG_SCAN_MASTER_IR_SKIP_EN
  logic                irv_q, irv_d;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rsp_q   <= '0;
      ir_q    <= '0;
      tck_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rsp_q   <= rsp_d;
      ir_q    <= ir_d;
      tck_q   <= tck_d;
    end
  end

`ifdef JTAG_SCAN_MASTER_IR_SKIP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irv_q <= 1'b0;
    else          irv_q <= irv_d;
  end
`endif

  assign accept     = cmd.cmd_valid && cmd.cmd_ready;
  assign period_end = (c_q == C_LAST);

  always_comb begin
    state_d = state_q;
    c_d     = period_end ? '0 : c_q + 1'b1;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rsp_d   = rsp_q;
    ir_d    = ir_q;
`ifdef JTAG_SCAN_MASTER_IR_SKIP_EN
    irv_d   = irv_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        c_d     = '0;
        state_d = S_IDLE;
        if (accept) begin
          state_d = S_UIR;
          tx_d    = cmd.cmd_dr;
          ir_d    = cmd.cmd_ir;
`ifdef JTAG_SCAN_MASTER_IR_SKIP_EN
          irv_d   = 1'b1;
          if (irv_q && cmd.cmd_ir == ir_q)
            state_d = S_CDR;
`endif
        end
      end
      S_UIR: if (period_end) state_d = S_CDR;
      S_CDR: begin
        if (period_end) begin
          state_d = S_SHIFT;
          bit_d   = '0;
        end
      end
      S_SHIFT: begin
        // TDO is taken on the edge that raises TCK
        if (c_q == C_RISE)
          rx_d = {vji_tdo, rx_q[DR_WIDTH-1:1]};
        if (period_end) begin
          tx_d = tx_q >> 1;
          if (bit_q == B_LAST) state_d = S_UDR;
          else                 bit_d   = bit_q + 1'b1;
        end
      end
      S_UDR: begin
        if (period_end) begin
          state_d = S_DONE;
          rsp_d   = rx_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    tck_d = (state_d != S_IDLE) && (state_d != S_DONE)
            && (c_d >= C_HI);
  end

  assign cmd.cmd_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign cmd.rsp_valid = (state_q == S_DONE);
  assign cmd.rsp_data  = rsp_q;
  assign cmd.busy      = (state_q != S_IDLE);

  assign vji_tck   = tck_q;
  assign vji_tdi   = (state_q == S_SHIFT) && tx_q[0];
  assign vji_ir_in = ir_q;
  assign vji_rti   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign vji_uir   = (state_q == S_UIR);
  assign vji_cdr   = (state_q == S_CDR);
  assign vji_sdr   = (state_q == S_SHIFT);
  assign vji_udr   = (state_q == S_UDR);

endmodule

// File: tb/tb_jtag_debug_scan_master.sv
// Directed bench for jtag_debug_scan_master with a loopback
// target shift register on the vji_* nets.
module tb_jtag_debug_scan_master;

  localparam int DW = 38;
  localparam int IW = 2;
`ifdef JTAG_SCAN_MASTER_IR_SKIP_EN
  localparam int SKIP_LAT = 321;
  localparam int SKIP_UIR = 0;
`else
  localparam int SKIP_LAT = 329;
  localparam int SKIP_UIR = 8;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          vji_tck, vji_tdi, vji_tdo;
  logic [IW-1:0] vji_ir_in;
  logic          vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr;

  jtag_debug_scan_master_if #(.DR_WIDTH(DW), .IR_WIDTH(IW)) bus();

  jtag_debug_scan_master #(
    .DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd      (bus),
    .vji_tck  (vji_tck),
    .vji_tdi  (vji_tdi),
    .vji_tdo  (vji_tdo),
    .vji_ir_in(vji_ir_in),
    .vji_rti  (vji_rti),
    .vji_uir  (vji_uir),
    .vji_cdr  (vji_cdr),
    .vji_sdr  (vji_sdr),
    .vji_udr  (vji_udr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // target: shifts only in SDR, tdo is its LSB
  logic [DW-1:0] sr;
  assign vji_tdo = sr[0];
  always @(posedge vji_tck)
    if (vji_sdr) sr = {vji_tdi, sr[DW-1:1]};

  int rises[$];
  always @(posedge vji_tck) rises.push_back(cyc);

  int n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0;
  int n_oh = 0, n_irbad = 0, n_rsp = 0;
  logic [IW-1:0] exp_ir = '0;
  always @(negedge clk) begin
    if (vji_uir) n_uir++;
    if (vji_cdr) n_cdr++;
    if (vji_sdr) n_sdr++;
    if (vji_udr) n_udr++;
    if (bus.rsp_valid) n_rsp++;
    if ($countones({vji_rti, vji_uir, vji_cdr,
                    vji_sdr, vji_udr}) != 1) n_oh++;
    if ((vji_uir | vji_cdr | vji_sdr | vji_udr)
        && vji_ir_in !== exp_ir) n_irbad++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, " cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    chk({p, " rti"},       64'(vji_rti), 64'd1);
    chk({p, " flags"},
        64'({vji_uir, vji_cdr, vji_sdr, vji_udr}), 64'd0);
    chk({p, " tck/tdi"},   64'({vji_tck, vji_tdi}), 64'd0);
    chk({p, " ir_in"},     64'(vji_ir_in), 64'd0);
    chk({p, " rsp/busy"},
        64'({bus.rsp_valid, bus.busy}), 64'd0);
    chk({p, " rsp_data"},  64'(bus.rsp_data), 64'd0);
  endtask

  task automatic issue(input logic [IW-1:0] ir,
                       input logic [DW-1:0] dr,
                       output int t0);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_ir    = ir;
    bus.cmd_dr    = dr;
    t0 = cyc;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int t0, t1, lat, b_rise, b_uir, b_cdr, b_sdr, b_udr, b_rsp, bad;

  initial begin
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_ir    = '0;
    bus.cmd_dr    = '0;
    sr            = '0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_reset("post-release");

    // loopback plus waveform shape
    sr = 38'h2A5A5AA5A5;
    exp_ir = 2'b01;
    b_rise = rises.size();
    b_uir = n_uir; b_cdr = n_cdr; b_sdr = n_sdr; b_udr = n_udr;
    issue(2'b01, 38'h150F0FF0F0, t0);
    chk("lb uir at cycle1", 64'(vji_uir), 64'd1);
    chk("lb ir_in", 64'(vji_ir_in), 64'h1);
    wait_rsp(t0, lat);
    chk("lb latency", 64'(lat), 64'd329);
    chk("lb rsp_data", 64'(bus.rsp_data), 64'h2A5A5AA5A5);
    chk("lb ready/busy@rsp",
        64'({bus.cmd_ready, bus.busy}), 64'h3);
    chk("lb target sr", 64'(sr), 64'h150F0FF0F0);
    chk("lb tck rises", 64'(rises.size() - b_rise), 64'd41);
    bad = 0;
    for (int i = b_rise + 1; i < rises.size(); i++)
      if (rises[i] - rises[i-1] != 8) bad++;
    chk("lb tck spacing", 64'(bad), 64'd0);
    chk("lb uir cycles", 64'(n_uir - b_uir), 64'd8);
    chk("lb cdr cycles", 64'(n_cdr - b_cdr), 64'd8);
    chk("lb sdr cycles", 64'(n_sdr - b_sdr), 64'd304);
    chk("lb udr cycles", 64'(n_udr - b_udr), 64'd8);
    @(negedge clk);
    chk("lb idle after", 64'({bus.rsp_valid, bus.busy}), 64'd0);
    chk("lb rsp held", 64'(bus.rsp_data), 64'h2A5A5AA5A5);

    // back-to-back; B is offered while A is still busy
    sr = 38'h0123456789;
    exp_ir = 2'b11;
    issue(2'b11, 38'h3F00FF00FF, t0);
    repeat (50) @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_ir    = 2'b00;
    bus.cmd_dr    = 38'h1234567890;
    wait_rsp(t0, lat);
    chk("b2b A latency", 64'(lat), 64'd329);
    chk("b2b A rsp_data", 64'(bus.rsp_data), 64'h0123456789);
    chk("b2b ready@rsp", 64'(bus.cmd_ready), 64'd1);
    t1 = cyc;
    exp_ir = 2'b00;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("b2b B uir next", 64'(vji_uir), 64'd1);
    chk("b2b B busy", 64'(bus.busy), 64'd1);
    wait_rsp(t1, lat);
    chk("b2b B latency", 64'(lat), 64'd329);
    chk("b2b B rsp_data", 64'(bus.rsp_data), 64'h3F00FF00FF);
    chk("b2b target sr", 64'(sr), 64'h1234567890);

    // reset during shift bit 20
    sr = 38'h155555555;
    exp_ir = 2'b01;
    issue(2'b01, 38'h0ABCDEF012, t0);
    for (int i = 0; i < 300 && (cyc - t0) < 180; i++)
      @(negedge clk);
    chk("mid sdr active", 64'(vji_sdr), 64'd1);
    #1 reset_n = 1'b0;
    #1 chk_reset("mid-reset");
    b_rsp = n_rsp;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (400) @(negedge clk);
    chk("mid no rsp", 64'(n_rsp - b_rsp), 64'd0);
    sr = 38'h2BADC0FFEE;
    issue(2'b01, 38'h1122334455, t0);
    wait_rsp(t0, lat);
    chk("post latency", 64'(lat), 64'd329);
    chk("post rsp_data", 64'(bus.rsp_data), 64'h2BADC0FFEE);
    chk("post target sr", 64'(sr), 64'h1122334455);

    // repeated IR
    sr = 38'h0F0F0F0F0F;
    exp_ir = 2'b10;
    issue(2'b10, 38'h3333333333, t0);
    wait_rsp(t0, lat);
    chk("ir1 latency", 64'(lat), 64'd329);
    chk("ir1 rsp_data", 64'(bus.rsp_data), 64'h0F0F0F0F0F);
    b_uir = n_uir;
    issue(2'b10, 38'h0CCCCCCCCC, t0);
    wait_rsp(t0, lat);
    chk("ir2 latency", 64'(lat), 64'(SKIP_LAT));
    chk("ir2 uir cycles", 64'(n_uir - b_uir), 64'(SKIP_UIR));
    chk("ir2 rsp_data", 64'(bus.rsp_data), 64'h3333333333);
    chk("ir2 target sr", 64'(sr), 64'h0CCCCCCCCC);

    chk("onehot violations", 64'(n_oh), 64'd0);
    chk("ir_in instability", 64'(n_irbad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, fails);
    $finish;
  end

endmodule
